pc_gen: RTL

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 24 ++
 rtl/pc_gen.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch program-counter generator.
package pc_gen_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned STATE_W = 2;

    localparam logic [PC_W-1:0] PC_STEP          = 32'd4;
    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [PC_W-1:0] DEFAULT_TRAP_PC  = 32'h0000_0100;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2,
        ST_TRAP  = 2'd3
    } pc_state_e;

    // Clear the byte-offset bits so a fetch address is always word aligned.
    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_gen.sv
// Fetch PC generator: run/stall/halt/trap FSM, PC register and accepted-fetch counter.
// Build option: define MISALIGN_TRAP_EN to trap on misaligned redirect targets.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [PC_W-1:0] TRAP_PC  = DEFAULT_TRAP_PC
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_target,
    input  logic                halt_req,
    input  logic                resume,
    output logic [PC_W-1:0]     pc,
    output logic                pc_valid,
    output logic [STATE_W-1:0]  state,
    output logic                trap,
    output logic [CNT_W-1:0]    fetch_count
);

    localparam logic [PC_W-1:0] RESET_PC_AL = word_align(RESET_PC);
    localparam logic [PC_W-1:0] TRAP_PC_AL  = word_align(TRAP_PC);

    pc_state_e         state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [PC_W-1:0]   redirect_pc;
    logic              misaligned;
    logic              accepted;

    assign redirect_pc = word_align(redirect_target);

`ifdef MISALIGN_TRAP_EN
    assign misaligned = |redirect_target[1:0];
`else
    // Offset bits are discarded when misaligned targets are simply rounded down.
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^redirect_target[1:0];
    assign misaligned         = 1'b0;
`endif

    // A live PC is consumed downstream whenever it is not back-pressured.
    assign accepted = valid_q && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC_AL;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;

        if (accepted) begin
            count_d = count_q + CNT_W'(1);
        end

        case (state_q)
            ST_RUN, ST_STALL: begin
                if (redirect_valid) begin
                    if (misaligned) begin
                        pc_d    = TRAP_PC_AL;
                        state_d = ST_TRAP;
                    end else begin
                        pc_d    = redirect_pc;
                        state_d = ST_RUN;
                    end
                end else if (halt_req) begin
                    state_d = ST_HALT;
                end else if (stall) begin
                    state_d = ST_STALL;
                end else begin
                    state_d = ST_RUN;
                    // The first cycle out of reset only presents RESET_PC.
                    if (valid_q) begin
                        pc_d = pc_q + PC_STEP;
                    end
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    if (misaligned) begin
                        pc_d    = TRAP_PC_AL;
                        state_d = ST_TRAP;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else if (!halt_req && resume) begin
                    state_d = ST_RUN;
                end
            end
            ST_TRAP: begin
                if (resume) begin
                    pc_d    = TRAP_PC_AL;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        valid_d = (state_d == ST_RUN) || (state_d == ST_STALL);
    end

`ifdef MISALIGN_TRAP_EN
    logic trap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= (state_d == ST_TRAP);
        end
    end

    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

    assign pc          = pc_q;
    assign pc_valid    = valid_q;
    assign state       = STATE_W'(state_q);
    assign fetch_count = count_q;

endmodule
